mips32_prefetch_queue: RTL and testbench

Instruction prefetch unit sitting directly upstream of the pipelined MIPS32 IF stage. It issues word-address reads to instruction memory over a req/ack bus, tolerating variable memory latency. Fetched instructions are buffered, each paired with its next-PC value, in a small FIFO that the IF stage drains through a valid/ready handshake. A redirect input lets a taken branch flush the queue and restart fetch at a new target. A halt input stops fetching after HLT.

---
 rtl/mips32_prefetch_queue_if.sv | 31 +++
 rtl/mips32_prefetch_queue.sv | 142 ++++++++++++++
 tb/tb_mips32_prefetch_queue.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips32_prefetch_queue_if.sv
// Bus bundle for the instruction prefetch queue: imem req/ack port, IF-stage dequeue
// port, and the redirect/halt controls.
interface mips32_prefetch_queue_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              deq_valid;
    logic [31:0]       deq_ir;
    logic [31:0]       deq_npc;
    logic              deq_ready;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              halt;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output deq_valid, deq_ir, deq_npc,
        input  deq_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  deq_valid, deq_ir, deq_npc,
        output deq_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/mips32_prefetch_queue.sv
// Instruction prefetcher: one outstanding imem read at a time, results buffered with
// their next-PC in a DEPTH-entry FIFO drained by the IF stage.
module mips32_prefetch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 10
) (
    input logic                    clk1,
    input logic                    rst,
    mips32_prefetch_queue_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic              halted_q, halted_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       ir_q  [DEPTH];
    logic [31:0]       npc_q [DEPTH];

    logic              halted_now;
    logic              push;
    logic              pop;
    logic              flush;
    logic [CNT_W-1:0]  count_pop;
    logic [31:0]       pc_inc;

    // addr_q is kept apart from fetch_pc_q so DISCARD can hold the old address
    // on the bus while fetch_pc already points at the redirect target.
    always_comb begin
        halted_now = halted_q | bus.halt;
        pop        = (count_q != '0) & bus.deq_ready & ~bus.redirect;
        count_pop  = count_q - CNT_W'(pop);
        pc_inc     = fetch_pc_q + 32'd1;
        flush      = bus.redirect;
        push       = 1'b0;
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        halted_d   = halted_now;

        case (state_q)
            IDLE: begin
                if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc;
                end else if (!halted_now && count_pop < FULL) begin
                    state_d = WAIT;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q[ADDR_W-1:0];
                end
            end
            WAIT: begin
                if (bus.imem_ack) begin
                    if (bus.redirect) begin
                        fetch_pc_d = bus.redirect_pc;
                        state_d    = IDLE;
                        req_d      = 1'b0;
                    end else begin
                        push       = 1'b1;
                        fetch_pc_d = pc_inc;
                        if (!halted_now && (count_pop + CNT_W'(1)) < FULL) begin
                            addr_d = pc_inc[ADDR_W-1:0];
                        end else begin
                            state_d = IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end else if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc;
                    state_d    = DISCARD;
                end
            end
            DISCARD: begin
                if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc;
                end
                if (bus.imem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        count_d = flush ? '0 : count_pop + CNT_W'(push);
        head_d  = flush ? '0 : head_q + PTR_W'(pop);
        tail_d  = flush ? '0 : tail_q + PTR_W'(push);
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            halted_q   <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            halted_q   <= halted_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ir_q[i]  <= '0;
                npc_q[i] <= '0;
            end
        end else if (push) begin
            ir_q[tail_q]  <= bus.imem_rdata;
            npc_q[tail_q] <= pc_inc;
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.deq_valid = (count_q != '0);
    assign bus.deq_ir    = ir_q[head_q];
    assign bus.deq_npc   = npc_q[head_q];
endmodule

// File: tb/tb_mips32_prefetch_queue.sv
// Directed bench for mips32_prefetch_queue: per-cycle vector table for streaming and
// full-queue behaviour, hand-written sequences for latency, redirect, halt and reset.
module tb_mips32_prefetch_queue;
    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    mips32_prefetch_queue_if #(.ADDR_W(10)) bus ();

    mips32_prefetch_queue #(.DEPTH(4), .ADDR_W(10)) dut (
        .clk1(clk1),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int lat = 1;
    bit resp_en = 1'b1;

    typedef struct {
        bit          first;
        bit          ready;
        bit          req;
        logic [9:0]  addr;
        bit          valid;
        logic [31:0] npc;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] memf(input logic [9:0] a);
        return 32'h8C00_0000 + ({22'h0, a} * 32'h0001_0003);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_head(input string nm, input logic [31:0] npc);
        logic [31:0] t;
        t = npc - 32'd1;
        chk({nm, "_valid"}, 32'(bus.deq_valid), 32'd1);
        chk({nm, "_npc"}, bus.deq_npc, npc);
        chk({nm, "_ir"}, bus.deq_ir, memf(t[9:0]));
    endtask

    task automatic cyc();
        @(posedge clk1);
        @(negedge clk1);
    endtask

    // Memory model: ack rises in the lat-th cycle that req is seen high.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(negedge clk1);
            #1;
            if (resp_en && bus.imem_req && !rst) begin
                wcnt++;
                if (wcnt >= lat) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = memf(bus.imem_addr);
                    wcnt = 0;
                end else begin
                    bus.imem_ack = 1'b0;
                end
            end else begin
                bus.imem_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    task automatic do_reset();
        rst             = 1'b1;
        bus.deq_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;
        resp_en         = 1'b1;
        lat             = 1;
        repeat (2) @(negedge clk1);
        chk("rst_req",   32'(bus.imem_req),  32'd0);
        chk("rst_addr",  32'(bus.imem_addr), 32'd0);
        chk("rst_valid", 32'(bus.deq_valid), 32'd0);
        chk("rst_ir",    bus.deq_ir,         32'd0);
        chk("rst_npc",   bus.deq_npc,        32'd0);
        rst = 1'b0;
    endtask

    initial begin
        bus.deq_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;

        // Streaming, ack every cycle, IF always ready.
        for (int k = 1; k <= 10; k++)
            tbl.push_back('{first: (k == 1), ready: 1'b1, req: 1'b1, addr: 10'(k - 1),
                            valid: (k >= 2), npc: 32'(k - 1)});
        // IF stalled: four pushes fill the queue, then a single pop reissues addr 4.
        tbl.push_back('{1, 0, 1, 10'd0, 0, 32'd0});
        tbl.push_back('{0, 0, 1, 10'd1, 1, 32'd1});
        tbl.push_back('{0, 0, 1, 10'd2, 1, 32'd1});
        tbl.push_back('{0, 0, 1, 10'd3, 1, 32'd1});
        tbl.push_back('{0, 0, 0, 10'd0, 1, 32'd1});
        tbl.push_back('{0, 0, 0, 10'd0, 1, 32'd1});
        tbl.push_back('{0, 1, 1, 10'd4, 1, 32'd2});
        tbl.push_back('{0, 0, 0, 10'd0, 1, 32'd2});

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].first) do_reset();
            bus.deq_ready = tbl[i].ready;
            cyc();
            chk($sformatf("v%0d_req", i), 32'(bus.imem_req), 32'(tbl[i].req));
            if (tbl[i].req) chk($sformatf("v%0d_addr", i), 32'(bus.imem_addr), 32'(tbl[i].addr));
            if (tbl[i].valid) chk_head($sformatf("v%0d", i), tbl[i].npc);
            else chk($sformatf("v%0d_valid", i), 32'(bus.deq_valid), 32'd0);
        end

        // Ack three cycles late: addr held four cycles, one entry per four cycles.
        do_reset();
        lat = 4;
        bus.deq_ready = 1'b1;
        for (int e = 0; e < 3; e++) begin
            for (int c = 0; c < 4; c++) begin
                cyc();
                chk("lat_req",  32'(bus.imem_req),  32'd1);
                chk("lat_addr", 32'(bus.imem_addr), 32'(e));
                if (c == 0 && e > 0) chk_head("lat", 32'(e));
                else chk("lat_valid", 32'(bus.deq_valid), 32'd0);
            end
        end

        // Redirect to 5 while waiting on addr 2 with no ack.
        do_reset();
        cyc(); chk("rd_a0", 32'(bus.imem_addr), 32'd0);
        cyc(); chk("rd_a1", 32'(bus.imem_addr), 32'd1);
        cyc(); chk("rd_a2", 32'(bus.imem_addr), 32'd2);
        chk_head("rd_pre", 32'd1);
        resp_en = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'd5;
        cyc();
        bus.redirect = 1'b0;
        chk("rd_flush_valid", 32'(bus.deq_valid), 32'd0);
        chk("rd_hold_req",    32'(bus.imem_req),  32'd1);
        chk("rd_hold_addr",   32'(bus.imem_addr), 32'd2);
        cyc();
        chk("rd_hold2_req",  32'(bus.imem_req),  32'd1);
        chk("rd_hold2_addr", 32'(bus.imem_addr), 32'd2);
        resp_en = 1'b1;
        cyc();
        chk("rd_drop_req",   32'(bus.imem_req),  32'd0);
        chk("rd_drop_valid", 32'(bus.deq_valid), 32'd0);
        cyc();
        chk("rd_new_req",  32'(bus.imem_req),  32'd1);
        chk("rd_new_addr", 32'(bus.imem_addr), 32'd5);
        cyc();
        chk_head("rd_first", 32'd6);

        // Redirect on the same edge as an ack, target at the top of memory.
        do_reset();
        bus.deq_ready = 1'b1;
        cyc(); chk("ra_a0", 32'(bus.imem_addr), 32'd0);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_03FF;
        cyc();
        bus.redirect = 1'b0;
        chk("ra_req",   32'(bus.imem_req),  32'd0);
        chk("ra_valid", 32'(bus.deq_valid), 32'd0);
        cyc();
        chk("ra_req2", 32'(bus.imem_req),  32'd1);
        chk("ra_a3ff", 32'(bus.imem_addr), 32'h3FF);
        cyc();
        chk_head("ra_e0", 32'h400);
        chk("ra_awrap", 32'(bus.imem_addr), 32'd0);
        cyc();
        chk_head("ra_e1", 32'h401);
        chk("ra_a1", 32'(bus.imem_addr), 32'd1);

        // Halt while the first request is pending.
        do_reset();
        lat = 4;
        cyc(); chk("h_a0", 32'(bus.imem_addr), 32'd0);
        bus.halt = 1'b1;
        cyc(); chk("h_req1", 32'(bus.imem_req), 32'd1);
        bus.halt = 1'b0;
        cyc(); chk("h_req2", 32'(bus.imem_req), 32'd1);
        cyc(); chk("h_req3", 32'(bus.imem_req), 32'd1);
        cyc();
        chk("h_req_off", 32'(bus.imem_req), 32'd0);
        chk_head("h_push", 32'd1);
        bus.deq_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            chk("h_noreq",  32'(bus.imem_req),  32'd0);
            chk("h_drained", 32'(bus.deq_valid), 32'd0);
        end

        // Reset restarts fetch at 0; a mid-stream async reset clears at once.
        do_reset();
        cyc();
        chk("rs_req",  32'(bus.imem_req),  32'd1);
        chk("rs_addr", 32'(bus.imem_addr), 32'd0);
        cyc();
        chk_head("rs_e0", 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_req",   32'(bus.imem_req),  32'd0);
        chk("async_valid", 32'(bus.deq_valid), 32'd0);
        chk("async_npc",   bus.deq_npc,        32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
